lcd_seq_ctrl: RTL and testbench

Sequencer for the character-LCD word driven onto `io_lcd_o`. It accepts byte-wide LCD commands and data from the store path through a small FIFO. On its own it runs the power-on initialisation sequence, then replays each queued entry as a correctly timed HD44780 write cycle: setup, enable pulse, hold and execution wait. Software no longer bit-bangs the enable line through the output-buffer LCD register; that register's output is replaced by this block's `io_lcd_o`.

---
 rtl/lcd_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lcd_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_seq_ctrl.sv
// HD44780 write sequencer: runs the power-on init sequence, then replays queued
// command/data bytes from a small FIFO as timed setup / enable / hold / wait cycles.
module lcd_seq_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int POR_CYC    = 750000,
    parameter int SETUP_CYC  = 3,
    parameter int PULSE_CYC  = 12,
    parameter int HOLD_CYC   = 3,
    parameter int EXEC_CYC   = 2000,
    parameter int CLR_CYC    = 82000
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        cmd_valid_i,
    input  logic                        cmd_rs_i,
    input  logic [7:0]                  cmd_data_i,
    output logic                        cmd_ready_o,
    output logic                        busy_o,
    output logic                        init_done_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic [31:0]                 io_lcd_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int MAX_A = (POR_CYC > CLR_CYC) ? POR_CYC : CLR_CYC;
    localparam int MAX_B = (EXEC_CYC > MAX_A) ? EXEC_CYC : MAX_A;
    localparam int TMR_W = ($clog2(MAX_B) > 20) ? $clog2(MAX_B) : 20;

    localparam logic [TMR_W-1:0] POR_LD   = TMR_W'(POR_CYC - 1);
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] EXEC_LD  = TMR_W'(EXEC_CYC - 1);
    localparam logic [TMR_W-1:0] CLR_LD   = TMR_W'(CLR_CYC - 1);
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_POR,
        S_ILOAD,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         idx_q, idx_d;
    logic               init_done_q, init_done_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               en_q;
    logic               on_q;

    logic [8:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     cnt_q, cnt_d;

    logic               full, empty, push, pop;
    logic               tmr_zero, wait_clr;
    logic [7:0]         init_byte;
    logic [8:0]         head;

    assign full     = (cnt_q == DEPTH_C);
    assign empty    = (cnt_q == '0);
    assign push     = cmd_valid_i && !full;
    assign head     = mem_q[rd_ptr_q];
    assign tmr_zero = (tmr_q == '0);
    // Clear and Home need the long execution wait; only instructions qualify
    assign wait_clr = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

    always_comb begin
        init_byte = 8'h06;
        case (idx_q)
            2'd0:    init_byte = 8'h38;
            2'd1:    init_byte = 8'h0C;
            2'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        data_d      = data_q;
        rs_d        = rs_q;
        pop         = 1'b0;
        case (state_q)
            S_POR: begin
                if (tmr_zero) begin
                    state_d = S_ILOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_ILOAD: begin
                data_d  = init_byte;
                rs_d    = 1'b0;
                tmr_d   = SETUP_LD;
                state_d = S_SETUP;
            end
            S_IDLE: begin
                if (init_done_q && !empty) begin
                    pop     = 1'b1;
                    rs_d    = head[8];
                    data_d  = head[7:0];
                    tmr_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    tmr_d   = PULSE_LD;
                    state_d = S_PULSE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_PULSE: begin
                if (tmr_zero) begin
                    tmr_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (tmr_zero) begin
                    tmr_d   = wait_clr ? CLR_LD : EXEC_LD;
                    state_d = S_WAIT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_WAIT: begin
                if (!tmr_zero) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (init_done_q) begin
                    state_d = S_IDLE;
                end else begin
                    // The last init entry completing hands control to the FIFO
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_ILOAD;
                    end
                end
            end
            default: begin
                tmr_d   = POR_LD;
                state_d = S_POR;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PTR_W + 1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_POR;
            tmr_q       <= POR_LD;
            idx_q       <= 2'd0;
            init_done_q <= 1'b0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            en_q        <= 1'b0;
            on_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            en_q        <= (state_d == S_PULSE);
            on_q        <= 1'b1;
            cnt_q       <= cnt_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: occupancy and pointers define what is valid
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_rs_i, cmd_data_i};
        end
    end

    assign cmd_ready_o = !full;
    assign busy_o      = on_q && ((state_q != S_IDLE) || !empty);
    assign init_done_o = init_done_q;
    assign fifo_cnt_o  = cnt_q;
    assign io_lcd_o    = {on_q, 20'd0, en_q, 1'b0, rs_q, data_q};

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: a cycle-level timeline model of LCD writes checked every
// cycle, plus literal checks of init timing, pulse shape, FIFO full and reset.
`timescale 1ns/1ps
module tb_lcd_seq_ctrl;

    localparam int DEPTH = 4;
    localparam int POR   = 10;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 5;
    localparam int CLR   = 20;
    localparam int HSIZE = 8192;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        valid  = 1'b0;
    logic        rsIn   = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        ready;
    logic        busy;
    logic        initDone;
    logic [2:0]  cnt;
    logic [31:0] io;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lcd_seq_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .POR_CYC    (POR),
        .SETUP_CYC  (SETUP),
        .PULSE_CYC  (PULSE),
        .HOLD_CYC   (HOLD),
        .EXEC_CYC   (EXEC),
        .CLR_CYC    (CLR)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .cmd_valid_i (valid),
        .cmd_rs_i    (rsIn),
        .cmd_data_i  (dataIn),
        .cmd_ready_o (ready),
        .busy_o      (busy),
        .init_done_o (initDone),
        .fifo_cnt_o  (cnt),
        .io_lcd_o    (io)
    );

    // Model: the sequencer is either counting down power-on, preparing an init
    // write, idle, or at position pos inside a write of wlen cycles.
    typedef enum int {M_POR, M_LEAD, M_WRITE, M_IDLE} mode_t;

    mode_t       mMode     = M_POR;
    logic [8:0]  mQ[$];
    int          porLeft   = POR;
    int          pos       = 0;
    int          wlen      = 1;
    int          initCount = 0;
    int          cyc       = 0;
    bit          mOn       = 1'b0;
    bit          mInitDone = 1'b0;
    bit          modelLive = 1'b0;
    bit          enPrev    = 1'b0;
    logic [7:0]  mData     = 8'h00;
    logic        mRs       = 1'b0;
    logic [7:0]  initRom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    logic [31:0] hist [HSIZE];
    int          riseQ[$];
    logic        expEn;
    logic [31:0] expIo;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cyc %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
        end
    endtask

    function automatic int writeLen(input logic r, input logic [7:0] d);
        bit isClr;
        isClr = (r == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
        return SETUP + PULSE + HOLD + (isClr ? CLR : EXEC);
    endfunction

    task automatic modelStep();
        bit pushOk;
        pushOk = valid && (mQ.size() < DEPTH);
        if (rst) begin
            modelLive = 1'b1;
            mOn       = 1'b0;
            mMode     = M_POR;
            porLeft   = POR;
            pos       = 0;
            wlen      = 1;
            initCount = 0;
            mInitDone = 1'b0;
            mData     = 8'h00;
            mRs       = 1'b0;
            cyc       = 0;
            mQ.delete();
            riseQ.delete();
        end else begin
            cyc++;
            mOn = 1'b1;
            case (mMode)
                M_POR: begin
                    if (porLeft == 1) mMode = M_LEAD;
                    else porLeft--;
                end
                M_LEAD: begin
                    mData = initRom[initCount];
                    mRs   = 1'b0;
                    pos   = 0;
                    wlen  = writeLen(mRs, mData);
                    mMode = M_WRITE;
                end
                M_IDLE: begin
                    if (mInitDone && (mQ.size() > 0)) begin
                        {mRs, mData} = mQ.pop_front();
                        pos   = 0;
                        wlen  = writeLen(mRs, mData);
                        mMode = M_WRITE;
                    end
                end
                default: begin
                    if (pos != wlen - 1) begin
                        pos++;
                    end else if (mInitDone) begin
                        mMode = M_IDLE;
                    end else begin
                        initCount++;
                        if (initCount == 4) begin
                            mInitDone = 1'b1;
                            mMode     = M_IDLE;
                        end else begin
                            mMode = M_LEAD;
                        end
                    end
                end
            endcase
            if (pushOk) mQ.push_back({rsIn, dataIn});
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (modelLive) begin
            expEn = (mMode == M_WRITE) && (pos >= SETUP) && (pos < SETUP + PULSE);
            expIo = {mOn, 20'd0, expEn, 1'b0, mRs, mData};
            checkOutput("io_lcd", io, expIo);
            checkOutput("ready", 32'(ready), 32'(mQ.size() < DEPTH));
            checkOutput("busy", 32'(busy), 32'(mOn && ((mMode != M_IDLE) || (mQ.size() != 0))));
            checkOutput("init_done", 32'(initDone), 32'(mInitDone));
            checkOutput("fifo_cnt", 32'(cnt), 32'(mQ.size()));
            if (cyc < HSIZE) hist[cyc] = io;
            if (io[10] && !enPrev) riseQ.push_back(cyc);
            enPrev = io[10];
        end
    end

    function automatic logic [31:0] histAt(input int i);
        if (i >= 0 && i < HSIZE) return hist[i];
        return 'x;
    endfunction

    function automatic int riseAt(input int i);
        if (i >= 0 && i < riseQ.size()) return riseQ[i];
        return -1;
    endfunction

    // One cycle: inputs set at the negedge, sampled at the posedge, return at next negedge
    task automatic applyStimulus(input logic v, input logic r, input logic [7:0] d);
        valid  = v;
        rsIn   = r;
        dataIn = d;
        @(negedge clk);
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end
        checkOutput("idle_wait", 32'(busy), 32'd0);
    endtask

    task automatic waitEn(input int bound);
        int n;
        n = 0;
        while (io[10] !== 1'b1 && n < bound) begin
            applyStimulus(1'b0, 1'b0, 8'h00);
            n++;
        end
        checkOutput("en_wait", 32'(io[10]), 32'd1);
    endtask

    int          base;
    int          r;
    int          expRise [6] = '{13, 27, 41, 70, 84, 98};
    logic [31:0] expRiseIo [6] = '{32'h8000_0438, 32'h8000_040C, 32'h8000_0401,
                                   32'h8000_0406, 32'h8000_0548, 32'h8000_0549};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_io", io, 32'd0);
        checkOutput("rst_ready", 32'(ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_init", 32'(initDone), 32'd0);
        checkOutput("rst_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;

        // Early pushes during POR, then the full init timeline
        applyStimulus(1'b1, 1'b1, 8'h48);
        applyStimulus(1'b1, 1'b1, 8'h49);
        waitCyc(5);
        checkOutput("por_io", io, 32'h8000_0000);
        checkOutput("por_cnt", 32'(cnt), 32'd2);
        checkOutput("por_busy", 32'(busy), 32'd1);
        waitCyc(10);
        checkOutput("por_end_io", io, 32'h8000_0000);
        waitCyc(11);
        checkOutput("init_setup_io", io, 32'h8000_0038);
        waitCyc(80);
        checkOutput("init_not_done", 32'(initDone), 32'd0);
        waitCyc(81);
        checkOutput("init_done", 32'(initDone), 32'd1);
        waitCyc(110);
        checkOutput("init_rise_count", 32'(riseQ.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("init_rise_cyc", 32'(riseAt(i)), 32'(expRise[i]));
            checkOutput("init_rise_io", histAt(riseAt(i)), expRiseIo[i]);
        end

        // Pulse shape of a single data write
        waitIdle(300);
        base = riseQ.size();
        applyStimulus(1'b1, 1'b1, 8'h41);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitEn(20);
        repeat (8) applyStimulus(1'b0, 1'b0, 8'h00);
        r = riseAt(base);
        for (int k = -2; k < 6; k++) begin
            checkOutput("pulse_shape", histAt(r + k),
                        (k >= 0 && k < PULSE) ? 32'h8000_0541 : 32'h8000_0141);
        end

        // FIFO full while a write is in progress
        waitIdle(300);
        base = riseQ.size();
        applyStimulus(1'b1, 1'b1, 8'h30);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitEn(20);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'h31 + i));
            if (i == 3) begin
                checkOutput("full_ready", 32'(ready), 32'd0);
                checkOutput("full_cnt", 32'(cnt), 32'd4);
            end
        end
        checkOutput("full_cnt_after5", 32'(cnt), 32'd4);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(300);
        checkOutput("full_rises", 32'(riseQ.size() - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            checkOutput("full_order", histAt(riseAt(base + i)) & 32'hFF, 32'(8'h30 + i));
        end

        // Clear gets the long wait, an ordinary instruction the short one
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 8'h01);
        applyStimulus(1'b1, 1'b1, 8'h5A);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(300);
        checkOutput("clr_gap", 32'(riseAt(base + 1) - riseAt(base)), 32'd29);
        base = riseQ.size();
        applyStimulus(1'b1, 1'b0, 8'h80);
        applyStimulus(1'b1, 1'b1, 8'h41);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(300);
        checkOutput("exec_gap", 32'(riseAt(base + 1) - riseAt(base)), 32'd14);

        // Random traffic with occasional resets, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, 8'h00);
                rst = 1'b0;
            end
            applyStimulus(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitIdle(600);

        // Reset in the middle of an enable pulse with two entries queued
        applyStimulus(1'b1, 1'b1, 8'h61);
        applyStimulus(1'b1, 1'b1, 8'h62);
        applyStimulus(1'b1, 1'b1, 8'h63);
        applyStimulus(1'b0, 1'b0, 8'h00);
        waitEn(20);
        checkOutput("pre_rst_cnt", 32'(cnt), 32'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("rst_mid_io", io, 32'd0);
        checkOutput("rst_mid_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        waitCyc(150);
        checkOutput("rst_reinit_done", 32'(initDone), 32'd1);
        checkOutput("rst_reinit_busy", 32'(busy), 32'd0);
        checkOutput("rst_reinit_cnt", 32'(cnt), 32'd0);
        checkOutput("rst_rises", 32'(riseQ.size()), 32'd4);
        checkOutput("rst_last_rise", 32'(riseAt(3)), 32'd70);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
